// File: rtl/capture_pkg.sv
// Shared types and constants for the packet capture limiter.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  // A packet limit of zero means the run continues until aborted.
  localparam int LIMIT_UNLIMITED = 0;

  // Default width of the limit and counter fields.
  localparam int CW_DEFAULT = 32;

endpackage

// File: rtl/packet_capture_limit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear has priority over increment; increment stops at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/packet_capture_limit.sv
// Passes a bounded number of whole AXI-Stream packets per capture run and
// discards everything outside a run so the upstream never stalls.
module packet_capture_limit
  import capture_pkg::*;
#(
  parameter int DW = 512,
  parameter int CW = CW_DEFAULT
) (
  input  logic            clk,
  input  logic            sys_resetn,
  input  logic            start,
  input  logic            abort,
  input  logic [CW-1:0]   max_packets,
  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic [DW/8-1:0] AXIS_IN_TKEEP,
  input  logic            AXIS_IN_TLAST,
  input  logic            AXIS_IN_TVALID,
  output logic            AXIS_IN_TREADY,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   packet_count,
  output logic [CW-1:0]   beat_count
);

  state_t        state_q, state_d;
  logic          in_packet_q;
  logic          done_q;
  logic          abort_pend_q;
  logic [CW-1:0] limit_q;

  logic          hs_in;
  logic          in_run;
  logic          latch_limit, cnt_clr, done_set, done_clr;
  logic          pend_set, pend_clr;
  logic          beat_inc, pkt_inc;
  logic          pend_eff, limit_hit;
  logic [CW-1:0] pkt_next;

  assign in_run = (state_q == RUN);

  // Zero-latency datapath: pass through during a run, otherwise sink input.
  assign AXIS_IN_TREADY  = in_run ? AXIS_OUT_TREADY : 1'b1;
  assign AXIS_OUT_TDATA  = in_run ? AXIS_IN_TDATA   : '0;
  assign AXIS_OUT_TKEEP  = in_run ? AXIS_IN_TKEEP   : '0;
  assign AXIS_OUT_TLAST  = in_run ? AXIS_IN_TLAST   : 1'b0;
  assign AXIS_OUT_TVALID = in_run ? AXIS_IN_TVALID  : 1'b0;

  assign hs_in = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // Packet count as it will be after this beat, saturated like the counter.
  assign pkt_next  = (packet_count == '1) ? packet_count : packet_count + CW'(1);
  assign limit_hit = (limit_q != CW'(LIMIT_UNLIMITED)) && (pkt_next == limit_q);
  assign pend_eff  = abort_pend_q | abort;

  // Next-state and control decode; start in IDLE beats a coincident abort.
  always_comb begin
    state_d     = state_q;
    latch_limit = 1'b0;
    cnt_clr     = 1'b0;
    done_set    = 1'b0;
    done_clr    = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    beat_inc    = 1'b0;
    pkt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_limit = 1'b1;
          cnt_clr     = 1'b1;
          done_clr    = 1'b1;
          pend_clr    = 1'b1;
          if ((!in_packet_q && !hs_in) || (hs_in && AXIS_IN_TLAST)) begin
            state_d = RUN;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else if (hs_in && AXIS_IN_TLAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        beat_inc = hs_in;
        pkt_inc  = hs_in & AXIS_IN_TLAST;
        pend_set = abort;
        if ((hs_in && AXIS_IN_TLAST && (limit_hit || pend_eff)) ||
            (pend_eff && !in_packet_q && !hs_in)) begin
          state_d  = IDLE;
          done_set = 1'b1;
          pend_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, packet tracking, sticky done, abort request and limit registers.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q      <= IDLE;
      in_packet_q  <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      limit_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hs_in) begin
        in_packet_q <= ~AXIS_IN_TLAST;
      end
      if (done_clr) begin
        done_q <= 1'b0;
      end else if (done_set) begin
        done_q <= 1'b1;
      end
      if (pend_clr) begin
        abort_pend_q <= 1'b0;
      end else if (pend_set) begin
        abort_pend_q <= 1'b1;
      end
      if (latch_limit) begin
        limit_q <= max_packets;
      end
    end
  end

  sat_counter #(.W(CW)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (sys_resetn),
    .clr   (cnt_clr),
    .inc   (pkt_inc),
    .q     (packet_count)
  );

  sat_counter #(.W(CW)) u_beat_cnt (
    .clk   (clk),
    .rst_n (sys_resetn),
    .clr   (cnt_clr),
    .inc   (beat_inc),
    .q     (beat_count)
  );

endmodule
